// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - processor, cache-array and memory signals of the data-cache controller
interface dcache_ctrl_if #(
    parameter int IDX_W = 4,
    parameter int BLK_W = 64
);
    localparam int TAG_W = 29 - IDX_W;

    logic             proc_req_valid;
    logic             proc_req_we;
    logic [31:0]      proc_req_addr;
    logic [BLK_W-1:0] proc_req_data;
    logic             proc_req_ready;
    logic             proc_resp_valid;
    logic [BLK_W-1:0] proc_resp_data;

    logic             cm_read_enable;
    logic             cm_write_enable;
    logic [TAG_W-1:0] cm_tag;
    logic [IDX_W-1:0] cm_index;
    logic [BLK_W-1:0] cm_wr_data;
    logic             cm_fill_enable;
    logic [BLK_W-1:0] cm_fill_data;
    logic             cm_fill_dirty;
    logic [BLK_W-1:0] cm_data_out;
    logic             cm_miss;
    logic             cm_dirty;
    logic [TAG_W-1:0] cm_dirty_tag;
    logic [IDX_W-1:0] cm_dirty_index;

    logic [1:0]       mem_command;
    logic [31:0]      mem_addr;
    logic [BLK_W-1:0] mem_wr_data;
    logic [3:0]       mem_response;
    logic [BLK_W-1:0] mem_data;
    logic [3:0]       mem_tag;

    modport master (
        input  proc_req_valid, proc_req_we, proc_req_addr, proc_req_data,
        output proc_req_ready, proc_resp_valid, proc_resp_data,
        output cm_read_enable, cm_write_enable, cm_tag, cm_index, cm_wr_data,
        output cm_fill_enable, cm_fill_data, cm_fill_dirty,
        input  cm_data_out, cm_miss, cm_dirty, cm_dirty_tag, cm_dirty_index,
        output mem_command, mem_addr, mem_wr_data,
        input  mem_response, mem_data, mem_tag
    );

    modport slave (
        output proc_req_valid, proc_req_we, proc_req_addr, proc_req_data,
        input  proc_req_ready, proc_resp_valid, proc_resp_data,
        input  cm_read_enable, cm_write_enable, cm_tag, cm_index, cm_wr_data,
        input  cm_fill_enable, cm_fill_data, cm_fill_dirty,
        output cm_data_out, cm_miss, cm_dirty, cm_dirty_tag, cm_dirty_index,
        input  mem_command, mem_addr, mem_wr_data,
        output mem_response, mem_data, mem_tag
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - blocking data-cache controller: lookup, victim write-back, fetch, fill, respond
module dcache_ctrl #(
    parameter int IDX_W = 4,
    parameter int BLK_W = 64
) (
    input logic           clock,
    input logic           reset,
    dcache_ctrl_if.master bus
);
    localparam int TAG_W = 29 - IDX_W;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FETCH, S_WAIT, S_FILL, S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] wdata_q, wdata_d;
    logic [31:0]      vaddr_q, vaddr_d;
    logic [BLK_W-1:0] vdata_q, vdata_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [3:0]       ptag_q, ptag_d;

    // Outputs are registered images of the next state, so every output is glitch-free.
    logic             o_ready_q, o_ready_d;
    logic             o_resp_valid_q, o_resp_valid_d;
    logic [BLK_W-1:0] o_resp_data_q, o_resp_data_d;
    logic             o_rd_en_q, o_rd_en_d;
    logic             o_wr_en_q, o_wr_en_d;
    logic [TAG_W-1:0] o_cm_tag_q, o_cm_tag_d;
    logic [IDX_W-1:0] o_cm_index_q, o_cm_index_d;
    logic [BLK_W-1:0] o_cm_wr_data_q, o_cm_wr_data_d;
    logic             o_fill_en_q, o_fill_en_d;
    logic [BLK_W-1:0] o_fill_data_q, o_fill_data_d;
    logic             o_fill_dirty_q, o_fill_dirty_d;
    logic [1:0]       o_mem_cmd_q, o_mem_cmd_d;
    logic [31:0]      o_mem_addr_q, o_mem_addr_d;
    logic [BLK_W-1:0] o_mem_wr_data_q, o_mem_wr_data_d;

    logic unused_offset;
    assign unused_offset = ^bus.proc_req_addr[2:0];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        vaddr_d = vaddr_q;
        vdata_d = vdata_q;
        data_d  = data_q;
        ptag_d  = ptag_q;
        case (state_q)
            S_IDLE: begin
                if (bus.proc_req_valid) begin
                    we_d    = bus.proc_req_we;
                    tag_d   = bus.proc_req_addr[31:3+IDX_W];
                    idx_d   = bus.proc_req_addr[3+IDX_W-1:3];
                    wdata_d = bus.proc_req_data;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!bus.cm_miss) begin
                    data_d  = we_q ? '0 : bus.cm_data_out;
                    state_d = S_RESP;
                end else begin
                    data_d = '0;
                    if (bus.cm_dirty) begin
                        vaddr_d = {bus.cm_dirty_tag, bus.cm_dirty_index, 3'b000};
                        vdata_d = bus.cm_data_out;
                        state_d = S_WB;
                    end else begin
                        // A store overwrites the whole block, so nothing needs fetching.
                        state_d = we_q ? S_FILL : S_FETCH;
                    end
                end
            end
            S_WB: begin
                if (bus.mem_response != 4'd0) state_d = we_q ? S_FILL : S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_response != 4'd0) begin
                    ptag_d  = bus.mem_response;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_tag != 4'd0 && bus.mem_tag == ptag_q) begin
                    data_d  = bus.mem_data;
                    state_d = S_FILL;
                end
            end
            S_FILL:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready_d       = 1'b0;
        o_resp_valid_d  = 1'b0;
        o_resp_data_d   = '0;
        o_rd_en_d       = 1'b0;
        o_wr_en_d       = 1'b0;
        o_cm_tag_d      = '0;
        o_cm_index_d    = '0;
        o_cm_wr_data_d  = '0;
        o_fill_en_d     = 1'b0;
        o_fill_data_d   = '0;
        o_fill_dirty_d  = 1'b0;
        o_mem_cmd_d     = CMD_NONE;
        o_mem_addr_d    = '0;
        o_mem_wr_data_d = '0;
        case (state_d)
            S_IDLE: o_ready_d = 1'b1;
            S_LOOKUP: begin
                o_cm_tag_d     = tag_d;
                o_cm_index_d   = idx_d;
                o_rd_en_d      = !we_d;
                o_wr_en_d      = we_d;
                o_cm_wr_data_d = wdata_d;
            end
            S_WB: begin
                o_mem_cmd_d     = CMD_STORE;
                o_mem_addr_d    = vaddr_d;
                o_mem_wr_data_d = vdata_d;
            end
            S_FETCH: begin
                o_mem_cmd_d  = CMD_LOAD;
                o_mem_addr_d = {tag_d, idx_d, 3'b000};
            end
            S_FILL: begin
                o_fill_en_d    = 1'b1;
                o_cm_tag_d     = tag_d;
                o_cm_index_d   = idx_d;
                o_fill_data_d  = we_d ? wdata_d : data_d;
                o_fill_dirty_d = we_d;
            end
            S_RESP: begin
                o_resp_valid_d = 1'b1;
                o_resp_data_d  = data_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            we_q            <= 1'b0;
            tag_q           <= '0;
            idx_q           <= '0;
            wdata_q         <= '0;
            vaddr_q         <= '0;
            vdata_q         <= '0;
            data_q          <= '0;
            ptag_q          <= '0;
            o_ready_q       <= 1'b1;
            o_resp_valid_q  <= 1'b0;
            o_resp_data_q   <= '0;
            o_rd_en_q       <= 1'b0;
            o_wr_en_q       <= 1'b0;
            o_cm_tag_q      <= '0;
            o_cm_index_q    <= '0;
            o_cm_wr_data_q  <= '0;
            o_fill_en_q     <= 1'b0;
            o_fill_data_q   <= '0;
            o_fill_dirty_q  <= 1'b0;
            o_mem_cmd_q     <= CMD_NONE;
            o_mem_addr_q    <= '0;
            o_mem_wr_data_q <= '0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            tag_q           <= tag_d;
            idx_q           <= idx_d;
            wdata_q         <= wdata_d;
            vaddr_q         <= vaddr_d;
            vdata_q         <= vdata_d;
            data_q          <= data_d;
            ptag_q          <= ptag_d;
            o_ready_q       <= o_ready_d;
            o_resp_valid_q  <= o_resp_valid_d;
            o_resp_data_q   <= o_resp_data_d;
            o_rd_en_q       <= o_rd_en_d;
            o_wr_en_q       <= o_wr_en_d;
            o_cm_tag_q      <= o_cm_tag_d;
            o_cm_index_q    <= o_cm_index_d;
            o_cm_wr_data_q  <= o_cm_wr_data_d;
            o_fill_en_q     <= o_fill_en_d;
            o_fill_data_q   <= o_fill_data_d;
            o_fill_dirty_q  <= o_fill_dirty_d;
            o_mem_cmd_q     <= o_mem_cmd_d;
            o_mem_addr_q    <= o_mem_addr_d;
            o_mem_wr_data_q <= o_mem_wr_data_d;
        end
    end

    assign bus.proc_req_ready  = o_ready_q;
    assign bus.proc_resp_valid = o_resp_valid_q;
    assign bus.proc_resp_data  = o_resp_data_q;
    assign bus.cm_read_enable  = o_rd_en_q;
    assign bus.cm_write_enable = o_wr_en_q;
    assign bus.cm_tag          = o_cm_tag_q;
    assign bus.cm_index        = o_cm_index_q;
    assign bus.cm_wr_data      = o_cm_wr_data_q;
    assign bus.cm_fill_enable  = o_fill_en_q;
    assign bus.cm_fill_data    = o_fill_data_q;
    assign bus.cm_fill_dirty   = o_fill_dirty_q;
    assign bus.mem_command     = o_mem_cmd_q;
    assign bus.mem_addr        = o_mem_addr_q;
    assign bus.mem_wr_data     = o_mem_wr_data_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - vector table, random transactions and reset corner for dcache_ctrl
module tb_dcache_ctrl;
    localparam int IDX_W = 4;
    localparam int BLK_W = 64;
    localparam int TAG_W = 29 - IDX_W;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dcache_ctrl_if #(.IDX_W(IDX_W), .BLK_W(BLK_W)) dif ();
    dcache_ctrl #(.IDX_W(IDX_W), .BLK_W(BLK_W)) dut (.clock(clock), .reset(reset), .bus(dif));

    typedef struct {
        logic             we;
        logic [31:0]      addr;
        logic [63:0]      wdata;
        logic             miss;
        logic             dirty;
        logic [TAG_W-1:0] vtag;
        logic [IDX_W-1:0] vidx;
        logic [63:0]      cdata;
        logic [63:0]      mdata;
        logic [3:0]       rtag;
        logic [3:0]       wtag;
        int               rwb;
        int               rf;
        int               dly;
        logic [63:0]      exp_resp;
        int               exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                                input logic miss, input logic dirty, input logic [TAG_W-1:0] vtag,
                                input logic [IDX_W-1:0] vidx, input logic [63:0] cdata,
                                input logic [63:0] mdata, input logic [3:0] rtag, input logic [3:0] wtag,
                                input int rwb, input int rf, input int dly,
                                input logic [63:0] exp_resp, input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.miss = miss; v.dirty = dirty;
        v.vtag = vtag; v.vidx = vidx; v.cdata = cdata; v.mdata = mdata;
        v.rtag = rtag; v.wtag = wtag; v.rwb = rwb; v.rf = rf; v.dly = dly;
        v.exp_resp = exp_resp; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference: a hit answers two cycles after acceptance; every miss adds a fill cycle,
    // a dirty victim adds its (retried) store, a load adds its (retried) fetch plus the reply wait.
    function automatic logic [63:0] model_resp(input vec_t v);
        if (v.we) return 64'd0;
        return v.miss ? v.mdata : v.cdata;
    endfunction

    function automatic int model_lat(input vec_t v);
        int lat = 2;
        if (v.miss) begin
            lat += 1;
            if (v.dirty) lat += 1 + v.rwb;
            if (!v.we) lat += 1 + v.rf + v.dly + 1;
        end
        return lat;
    endfunction

    task automatic drive_idle();
        dif.proc_req_valid = 1'b0; dif.proc_req_we = 1'b0;
        dif.proc_req_addr = '0; dif.proc_req_data = '0;
        dif.cm_data_out = '0; dif.cm_miss = 1'b0; dif.cm_dirty = 1'b0;
        dif.cm_dirty_tag = '0; dif.cm_dirty_index = '0;
        dif.mem_response = '0; dif.mem_data = '0; dif.mem_tag = '0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int n_look = 0, n_fill = 0, n_st = 0, n_ld = 0, st_cyc = 0, ld_cyc = 0;
        int bad_st = 0, bad_ld = 0, bad_ready = 0, bad_cmd = 0;
        int rej_wb = v.rwb, rej_f = v.rf, dly = v.dly, acc, lat = -1;
        logic ld_done = 1'b0, seen = 1'b0, lk_we = 1'b0, f_dirty = 1'b0;
        logic [TAG_W-1:0] lk_tag = '0, f_tag = '0;
        logic [IDX_W-1:0] lk_idx = '0, f_idx = '0;
        logic [63:0] lk_wd = '0, f_data = '0, r_data = '0;
        logic [31:0] vaddr = {v.vtag, v.vidx, 3'b000};
        logic [31:0] laddr = {v.addr[31:3], 3'b000};
        string pfx = $sformatf("v%0d", n);

        @(negedge clock);
        chk({pfx, "_ready_idle"}, 64'(dif.proc_req_ready), 64'd1);
        dif.proc_req_valid = 1'b1; dif.proc_req_we = v.we;
        dif.proc_req_addr = v.addr; dif.proc_req_data = v.wdata;
        dif.cm_miss = v.miss; dif.cm_dirty = v.dirty; dif.cm_data_out = v.cdata;
        dif.cm_dirty_tag = v.vtag; dif.cm_dirty_index = v.vidx;
        dif.mem_response = '0; dif.mem_tag = '0;
        acc = cyc;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            // Unrelated request traffic while busy must be ignored.
            dif.proc_req_valid = 1'b1;
            dif.proc_req_we    = 1'($urandom_range(0, 1));
            dif.proc_req_addr  = $urandom;
            dif.proc_req_data  = {$urandom, $urandom};
            dif.mem_response   = '0;
            if (dif.proc_req_ready) bad_ready++;
            if (dif.cm_read_enable || dif.cm_write_enable) begin
                n_look++; lk_we = dif.cm_write_enable;
                lk_tag = dif.cm_tag; lk_idx = dif.cm_index; lk_wd = dif.cm_wr_data;
                if (dif.cm_read_enable && dif.cm_write_enable) bad_cmd++;
            end
            if (ld_done) begin
                if (dly > 0) begin
                    dif.mem_tag = v.wtag; dif.mem_data = {$urandom, $urandom}; dly--;
                end else begin
                    dif.mem_tag = v.rtag; dif.mem_data = v.mdata;
                end
            end
            case (dif.mem_command)
                2'd2: begin
                    st_cyc++;
                    if (dif.mem_addr !== vaddr || dif.mem_wr_data !== v.cdata) bad_st++;
                    if (rej_wb > 0) rej_wb--;
                    else begin dif.mem_response = 4'hF; n_st++; end
                end
                2'd1: begin
                    ld_cyc++;
                    if (dif.mem_addr !== laddr) bad_ld++;
                    if (rej_f > 0) rej_f--;
                    else begin dif.mem_response = v.rtag; n_ld++; ld_done = 1'b1; end
                end
                2'd0: ;
                default: bad_cmd++;
            endcase
            if (dif.cm_fill_enable) begin
                n_fill++; f_tag = dif.cm_tag; f_idx = dif.cm_index;
                f_data = dif.cm_fill_data; f_dirty = dif.cm_fill_dirty;
            end
            if (dif.proc_resp_valid) begin
                seen = 1'b1; r_data = dif.proc_resp_data; lat = cyc - acc;
                dif.proc_req_valid = 1'b0;
            end
        end
        @(negedge clock);
        dif.mem_tag = '0; dif.mem_response = '0;
        chk({pfx, "_resp_seen"}, 64'(seen), 64'd1);
        chk({pfx, "_resp_pulse"}, 64'(dif.proc_resp_valid), 64'd0);
        chk({pfx, "_ready_after"}, 64'(dif.proc_req_ready), 64'd1);
        chk({pfx, "_resp_data"}, r_data, v.exp_resp);
        chk({pfx, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({pfx, "_ready_busy"}, 64'(bad_ready), 64'd0);
        chk({pfx, "_lookups"}, 64'(n_look), 64'd1);
        chk({pfx, "_lk_we"}, 64'(lk_we), 64'(v.we));
        chk({pfx, "_lk_tag"}, 64'(lk_tag), 64'(v.addr[31:3+IDX_W]));
        chk({pfx, "_lk_idx"}, 64'(lk_idx), 64'(v.addr[3+IDX_W-1:3]));
        chk({pfx, "_lk_wdata"}, lk_wd, v.wdata);
        chk({pfx, "_bad_cmd"}, 64'(bad_cmd), 64'd0);
        chk({pfx, "_stores"}, 64'(n_st), 64'(v.miss && v.dirty));
        chk({pfx, "_store_cycles"}, 64'(st_cyc), (v.miss && v.dirty) ? 64'(1 + v.rwb) : 64'd0);
        chk({pfx, "_store_addr_data"}, 64'(bad_st), 64'd0);
        chk({pfx, "_loads"}, 64'(n_ld), 64'(v.miss && !v.we));
        chk({pfx, "_load_cycles"}, 64'(ld_cyc), (v.miss && !v.we) ? 64'(1 + v.rf) : 64'd0);
        chk({pfx, "_load_addr"}, 64'(bad_ld), 64'd0);
        chk({pfx, "_fills"}, 64'(n_fill), 64'(v.miss));
        if (v.miss) begin
            chk({pfx, "_fill_data"}, f_data, v.we ? v.wdata : v.mdata);
            chk({pfx, "_fill_dirty"}, 64'(f_dirty), 64'(v.we));
            chk({pfx, "_fill_tag"}, 64'(f_tag), 64'(v.addr[31:3+IDX_W]));
            chk({pfx, "_fill_idx"}, 64'(f_idx), 64'(v.addr[3+IDX_W-1:3]));
        end
    endtask

    initial begin
        int n_fill, n_resp, guard;
        reset = 1'b1;
        drive_idle();

        vecs.push_back(mk(1'b0, 32'h0000_0100, 64'h0, 1'b0, 1'b0, '0, '0, 64'hDEAD_BEEF, 64'h0,
                          4'd1, 4'd2, 0, 0, 0, 64'hDEAD_BEEF, 2));
        vecs.push_back(mk(1'b0, 32'h0000_1230, 64'h0, 1'b1, 1'b0, '0, '0, 64'h0, 64'h55,
                          4'd3, 4'd4, 0, 0, 0, 64'h55, 5));
        vecs.push_back(mk(1'b0, 32'h0000_4568, 64'h0, 1'b1, 1'b1, 25'd5, 4'd2, 64'hCAFE_F00D, 64'h99,
                          4'd4, 4'd7, 0, 0, 2, 64'h99, 8));
        vecs.push_back(mk(1'b1, 32'h0000_2040, 64'hA5, 1'b1, 1'b0, '0, '0, 64'h0, 64'h0,
                          4'd1, 4'd2, 0, 0, 0, 64'h0, 3));
        vecs.push_back(mk(1'b0, 32'h0000_8888, 64'h0, 1'b1, 1'b0, '0, '0, 64'h0, 64'h1234,
                          4'd2, 4'd3, 0, 3, 0, 64'h1234, 8));
        vecs.push_back(mk(1'b1, 32'h0000_0FF8, 64'h1111, 1'b0, 1'b0, '0, '0, 64'hFFFF, 64'h0,
                          4'd1, 4'd2, 0, 0, 0, 64'h0, 2));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFF8, 64'h2222, 1'b1, 1'b1, 25'h1AB_CDEF, 4'hF, 64'h3333, 64'h0,
                          4'd1, 4'd2, 2, 0, 0, 64'h0, 6));
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.we = 1'($urandom_range(0, 1)); v.addr = $urandom; v.wdata = {$urandom, $urandom};
            v.miss = 1'($urandom_range(0, 1)); v.dirty = 1'($urandom_range(0, 1));
            v.vtag = TAG_W'($urandom); v.vidx = IDX_W'($urandom);
            v.cdata = {$urandom, $urandom}; v.mdata = {$urandom, $urandom};
            v.rtag = 4'($urandom_range(1, 15)); v.wtag = 4'((v.rtag % 15) + 1);
            v.rwb = $urandom_range(0, 3); v.rf = $urandom_range(0, 3); v.dly = $urandom_range(0, 3);
            v.exp_resp = model_resp(v); v.exp_lat = model_lat(v);
            vecs.push_back(v);
        end

        repeat (2) @(negedge clock);
        chk("reset_ready", 64'(dif.proc_req_ready), 64'd1);
        chk("reset_resp_valid", 64'(dif.proc_resp_valid), 64'd0);
        chk("reset_mem_cmd", 64'(dif.mem_command), 64'd0);
        chk("reset_mem_addr", 64'(dif.mem_addr), 64'd0);
        chk("reset_cm_en", 64'({dif.cm_read_enable, dif.cm_write_enable, dif.cm_fill_enable}), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset while waiting for the memory reply: request is dropped, late reply ignored.
        @(negedge clock);
        dif.proc_req_valid = 1'b1; dif.proc_req_we = 1'b0; dif.proc_req_addr = 32'h0000_1230;
        dif.cm_miss = 1'b1; dif.cm_dirty = 1'b0;
        guard = 0;
        @(negedge clock);
        dif.proc_req_valid = 1'b0;
        while (dif.mem_command != 2'd1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("rst_load_issued", 64'(dif.mem_command), 64'd1);
        dif.mem_response = 4'd6;
        @(negedge clock);
        dif.mem_response = 4'd0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_wait_ready", 64'(dif.proc_req_ready), 64'd1);
        chk("rst_wait_mem_cmd", 64'(dif.mem_command), 64'd0);
        n_fill = 0; n_resp = 0;
        dif.mem_tag = 4'd6; dif.mem_data = 64'hBAD0_BAD0;
        repeat (6) begin
            @(negedge clock);
            if (dif.cm_fill_enable) n_fill++;
            if (dif.proc_resp_valid) n_resp++;
        end
        dif.mem_tag = 4'd0;
        chk("rst_late_fill", 64'(n_fill), 64'd0);
        chk("rst_late_resp", 64'(n_resp), 64'd0);
        chk("rst_late_ready", 64'(dif.proc_req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter: IDX_W, 4, cache index width; TAG_W is derived as 29-IDX_W.
REQ-002 SHALL have parameter: BLK_W, 64, block and data width in bits (8-byte block).
REQ-003 SHALL have ports: clock in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-004 SHALL have ports: proc_req_valid in 1; proc_req_we in 1 (1=store); proc_req_addr in 32; proc_req_data in BLK_W; proc_req_ready out 1.
REQ-005 SHALL have ports: proc_resp_valid out 1; proc_resp_data out BLK_W.
REQ-006 SHALL have cache-array ports: cm_read_enable out 1; cm_write_enable out 1; cm_tag out TAG_W; cm_index out IDX_W; cm_wr_data out BLK_W.
REQ-007 SHALL have cache-array fill ports: cm_fill_enable out 1; cm_fill_data out BLK_W; cm_fill_dirty out 1.
REQ-008 SHALL have cache-array inputs: cm_data_out in BLK_W; cm_miss in 1; cm_dirty in 1; cm_dirty_tag in TAG_W; cm_dirty_index in IDX_W.
REQ-009 SHALL have memory ports: mem_command out 2 (0=NONE, 1=LOAD, 2=STORE); mem_addr out 32; mem_wr_data out BLK_W; mem_response in 4; mem_data in BLK_W; mem_tag in 4.

Function
REQ-010 SHALL split addresses as: offset=addr[2:0] (ignored), index=addr[3+IDX_W-1:3], tag=addr[31:3+IDX_W].
REQ-011 SHALL implement FSM states IDLE, LOOKUP, WB, FETCH, WAIT, FILL, RESP.
REQ-012 SHALL assert proc_req_ready only in IDLE.
REQ-013 IDLE: on proc_req_valid, SHALL latch we/addr/data and go to LOOKUP; otherwise SHALL stay in IDLE.
REQ-014 LOOKUP: SHALL drive cm_tag/cm_index from the latched address, cm_read_enable=!we and cm_write_enable=we, and cm_wr_data=latched data.
REQ-015 LOOKUP with cm_miss=0: SHALL go to RESP, capturing cm_data_out for loads and 0 for stores.
REQ-016 LOOKUP with cm_miss=1 and cm_dirty=1: SHALL capture the victim as addr {cm_dirty_tag,cm_dirty_index,3'b0} with data cm_data_out, and go to WB.
REQ-017 LOOKUP with cm_miss=1 and cm_dirty=0: a store SHALL go directly to FILL (full-block write, no fetch); a load SHALL go to FETCH.
REQ-018 WB: SHALL drive mem_command=STORE with the victim addr/data, held stable until mem_response!=0; then a store SHALL go to FILL and a load to FETCH.
REQ-019 FETCH: SHALL drive mem_command=LOAD with mem_addr={tag,index,3'b0}, held until mem_response!=0; SHALL then latch mem_response as the pending tag and go to WAIT.
REQ-020 mem_response==0 SHALL mean "rejected"; the controller SHALL retry the same command in the following cycle.
REQ-021 WAIT: when mem_tag!=0 and mem_tag equals the pending tag, SHALL capture mem_data and go to FILL; any other mem_tag SHALL be ignored.
REQ-022 FILL: SHALL pulse cm_fill_enable for exactly one cycle, with cm_tag/cm_index set to the request, and then go to RESP.
REQ-023 FILL data/dirty: for a store, cm_fill_data=latched data and cm_fill_dirty=1; for a load, cm_fill_data=fetched data and cm_fill_dirty=0.
REQ-024 RESP: SHALL assert proc_resp_valid for exactly one cycle (data = load value, 0 for stores) and return to IDLE.
REQ-025 Latency: a hit SHALL respond 2 cycles after acceptance; mem_command SHALL be NONE and cm enables 0 in all states not listed above.
REQ-026 Requests SHALL be strictly serialized, one outstanding at a time; proc_req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE, and all outputs SHALL be 0 except proc_req_ready=1.
REQ-028 Reset mid-operation SHALL abandon the request without a response, and late memory replies SHALL be ignored.

Verification
REQ-029 Load hit: cm_miss=0, cm_data_out=64'hDEAD_BEEF -> proc_resp_valid at cycle+2 with data 64'hDEAD_BEEF, mem_command stays NONE.
REQ-030 Clean load miss to 32'h0000_1230: LOAD issued at addr 32'h0000_1230; mem_response=3, then mem_tag=3 with data 64'h55 -> one-cycle fill with dirty=0, then resp data 64'h55.
REQ-031 Dirty load miss: victim tag 5, index 2 -> STORE at {5,2,000} with victim data, then LOAD; mem_tag=7 while pending tag=4 is ignored.
REQ-032 Clean store miss with data 64'hA5 -> no mem_command issued, cm_fill_dirty=1 with data 64'hA5, then resp_valid.
REQ-033 mem_response=0 for 3 cycles during FETCH -> LOAD held with the same addr for 4 cycles; on accept, exactly one LOAD is counted.
REQ-034 Reset asserted in WAIT -> IDLE next cycle with proc_req_ready=1; later mem_tag match produces no fill and no response.
